// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the frame-buffer SRAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_arbiter_pkg;

  // Frame-buffer address width (640x750 bytes fit in 19 bits).
  localparam int ADDR_W = 19;

  // First address past the end of the frame buffer.
  localparam int ADDR_LIMIT_DEF = 480000;

  // Arbiter ownership of the single SRAM controller slot.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DISP_BUSY = 2'd1,
    HOST_BUSY = 2'd2
  } arb_state_t;

endpackage

// File: rtl/sram_arb_select.sv
// Request select: picks display or host while idle, flags out-of-range host access, tracks starvation.
// Latency: purely combinational; the caller registers every result.
// Backpressure: none here; losing requester simply keeps its request up.
module sram_arb_select
  import sram_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 8,
  parameter int ADDR_LIMIT = ADDR_LIMIT_DEF,
  parameter int SW         = 4
) (
  input  logic              idle,
  input  logic              disp_req,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [SW-1:0]     starve_cnt,
  output logic              grant_disp,
  output logic              grant_host,
  output logic              host_reject,
  output logic [SW-1:0]     starve_next
);

  localparam logic [SW-1:0] SMAX  = SW'(STARVE_MAX);
  localparam logic [31:0]   LIMIT = 32'(ADDR_LIMIT);

  logic host_first;

  // Display normally wins; host takes over once it has watched SMAX display grants go by.
  always_comb begin
    host_first  = host_req && (!disp_req || (starve_cnt == SMAX));
    grant_disp  = idle && disp_req && !host_first;
    grant_host  = idle && host_first;
    host_reject = grant_host && (32'(host_addr) >= LIMIT);
    // A host grant (even a rejected one) or an absent host request ends any starvation run.
    if (grant_host || !host_req) begin
      starve_next = '0;
    end else if (grant_disp && (starve_cnt != SMAX)) begin
      starve_next = starve_cnt + 1'b1;
    end else begin
      starve_next = starve_cnt;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM controller between the VGA pixel fetch and the host port, one transaction at a time.
// Latency: grant one edge after request seen in IDLE; valid/done one edge after mem_done; watchdog aborts after TIMEOUT busy cycles.
// Backpressure: requesters hold req until their gnt pulse; nothing is queued inside.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 8,
  parameter int TIMEOUT    = 15,
  parameter int ADDR_LIMIT = ADDR_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic [7:0]        disp_rdata,
  output logic              disp_valid,
  input  logic              host_req,
  input  logic              host_rw,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic              host_gnt,
  output logic [7:0]        host_rdata,
  output logic              host_done,
  output logic              host_err,
  output logic              mem_trig,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_done,
  output logic              timeout_flag
);

  localparam int            SW      = $clog2(STARVE_MAX + 1);
  localparam int            WW      = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  arb_state_t    state;
  logic [SW-1:0] starve_cnt;
  logic [SW-1:0] starve_next;
  logic [WW-1:0] wd_cnt;
  logic          grant_disp;
  logic          grant_host;
  logic          host_reject;

  sram_arb_select #(
    .STARVE_MAX (STARVE_MAX),
    .ADDR_LIMIT (ADDR_LIMIT),
    .SW         (SW)
  ) u_select (
    .idle        (state == IDLE),
    .disp_req    (disp_req),
    .host_req    (host_req),
    .host_addr   (host_addr),
    .starve_cnt  (starve_cnt),
    .grant_disp  (grant_disp),
    .grant_host  (grant_host),
    .host_reject (host_reject),
    .starve_next (starve_next)
  );

  // Ownership FSM: grant, wait for mem_done or watchdog expiry, then release; all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      wd_cnt       <= '0;
      disp_gnt     <= 1'b0;
      disp_rdata   <= '0;
      disp_valid   <= 1'b0;
      host_gnt     <= 1'b0;
      host_rdata   <= '0;
      host_done    <= 1'b0;
      host_err     <= 1'b0;
      mem_trig     <= 1'b0;
      mem_rw       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      timeout_flag <= 1'b0;
    end else begin
      // Pulse outputs default low; mem_* hold so the controller sees stable operands.
      disp_gnt   <= 1'b0;
      disp_valid <= 1'b0;
      host_gnt   <= 1'b0;
      host_done  <= 1'b0;
      host_err   <= 1'b0;
      mem_trig   <= 1'b0;
      starve_cnt <= starve_next;
      case (state)
        IDLE: begin
          // mem_done arriving here belongs to no transaction and is dropped.
          if (grant_disp) begin
            disp_gnt <= 1'b1;
            mem_trig <= 1'b1;
            mem_rw   <= 1'b1;
            mem_addr <= disp_addr;
            wd_cnt   <= '0;
            state    <= DISP_BUSY;
          end else if (grant_host) begin
            host_gnt <= 1'b1;
            if (host_reject) begin
              host_err <= 1'b1;
            end else begin
              mem_trig  <= 1'b1;
              mem_rw    <= host_rw;
              mem_addr  <= host_addr;
              mem_wdata <= host_wdata;
              wd_cnt    <= '0;
              state     <= HOST_BUSY;
            end
          end
        end
        DISP_BUSY, HOST_BUSY: begin
          // A completion on the last watchdog cycle still counts as a completion.
          if (mem_done) begin
            if (state == DISP_BUSY) begin
              disp_rdata <= mem_rdata;
              disp_valid <= 1'b1;
            end else begin
              host_done <= 1'b1;
              if (mem_rw) begin
                host_rdata <= mem_rdata;
              end
            end
            state <= IDLE;
          end else if (wd_cnt == WD_LAST) begin
            timeout_flag <= 1'b1;
            if (state == HOST_BUSY) begin
              host_err <= 1'b1;
            end
            state <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
